// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer (bcd_timer_pkg).
// Optional feature macro used by the top: BCD_TIMER_AUTO_RELOAD_EN.
package bcd_timer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } timer_state_t;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
      return (nib > BCD_MAX) ? BCD_MAX : nib;
   endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the keypad logic (master) and the timer (slave).
interface bcd_countdown_timer_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   load_val;
   logic                      start;
   logic                      pause;
   logic                      tick_in;
   logic [4*NUM_DIGITS-1:0]   count;
   logic                      running;
   logic                      done;
   logic                      expired;
   logic                      load_err;

   modport master (
      output load, load_val, start, pause, tick_in,
      input  count, running, done, expired, load_err
   );

   modport slave (
      input  load, load_val, start, pause, tick_in,
      output count, running, done, expired, load_err
   );
endinterface

// File: rtl/bcd_countdown_timer_down_cell.sv
// One down-counting BCD digit; load has priority over decrement.
module bcd_down_cell
   import bcd_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       dec_in,
   input  logic       load_en,
   input  logic [3:0] load_nib,
   output logic [3:0] nib,
   output logic       borrow_out,
   output logic       is_zero
);

   assign is_zero    = (nib == BCD_ZERO);
   assign borrow_out = dec_in & is_zero;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         nib <= BCD_ZERO;
      else if (load_en)
         nib <= load_nib;
      else if (dec_in)
         nib <= is_zero ? BCD_MAX : nib - 4'd1;
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: control FSM, tick prescaler and digit chain.
// Optional feature: define BCD_TIMER_AUTO_RELOAD_EN to reload the last preset on expiry.
module bcd_countdown_timer
   import bcd_timer_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned PRESCALE   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   bcd_countdown_timer_if.slave  bus
);

   localparam int unsigned   W       = 4 * NUM_DIGITS;
   localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   timer_state_t            state, state_nxt;
   logic [PW-1:0]           pre, pre_nxt;
   logic                    done_q, done_nxt;
   logic                    err_q, err_nxt;
   logic                    dec, reload, reload_ok, cell_load;
   logic                    count_zero, one_left;
   logic [W-1:0]            count, clamped, load_src;
   logic [NUM_DIGITS-1:0]   bad, zero, borrow;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic dec_in;
      if (i == 0) begin : g_lsd
         assign dec_in = dec;
      end else begin : g_upper
         // A digit only sees the decrement when every lower digit was zero.
         assign dec_in = borrow[i-1];
      end
      assign clamped[4*i +: 4] = bcd_clamp(bus.load_val[4*i +: 4]);
      assign bad[i]            = (bus.load_val[4*i +: 4] > BCD_MAX);

      bcd_down_cell u_cell (
         .clk        (clk),
         .rst        (rst),
         .dec_in     (dec_in),
         .load_en    (cell_load),
         .load_nib   (load_src[4*i +: 4]),
         .nib        (count[4*i +: 4]),
         .borrow_out (borrow[i]),
         .is_zero    (zero[i])
      );
   end

`ifdef BCD_TIMER_AUTO_RELOAD_EN
   logic [W-1:0] shadow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         shadow <= '0;
      else if (bus.load)
         shadow <= clamped;
   end

   // An all-zero preset cannot be reloaded, so expiry falls back to DONE.
   assign reload_ok = |shadow;
   assign load_src  = bus.load ? clamped : shadow;
`else
   assign reload_ok = 1'b0;
   assign load_src  = clamped;
`endif

   assign count_zero = &zero;
   assign one_left   = (count == W'(1));
   assign cell_load  = bus.load | reload;

   always_comb begin
      state_nxt = state;
      pre_nxt   = pre;
      done_nxt  = 1'b0;
      err_nxt   = err_q;
      dec       = 1'b0;
      reload    = 1'b0;
      if (bus.load) begin
         state_nxt = IDLE;
         pre_nxt   = '0;
         err_nxt   = |bad;
      end else begin
         case (state)
            IDLE:   if (bus.start && !count_zero) state_nxt = RUN;
            RUN: begin
               if (bus.pause && !bus.start) begin
                  state_nxt = PAUSED;
               end else if (bus.tick_in) begin
                  if (pre == PS_LAST) begin
                     pre_nxt = '0;
                     dec     = 1'b1;
                     if (one_left) begin
                        done_nxt = 1'b1;
                        if (reload_ok) reload    = 1'b1;
                        else           state_nxt = DONE;
                     end
                  end else begin
                     pre_nxt = pre + PW'(1);
                  end
               end
            end
            PAUSED: if (bus.start) state_nxt = RUN;
            DONE:   state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         pre    <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         pre    <= pre_nxt;
         done_q <= done_nxt;
         err_q  <= err_nxt;
      end
   end

   no_top_borrow: assert property (@(posedge clk) disable iff (!rst) !borrow[NUM_DIGITS-1]);

   assign bus.count    = count;
   assign bus.running  = (state == RUN);
   assign bus.done     = done_q;
   assign bus.expired  = (state == DONE);
   assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: two timers (PRESCALE 1 and 4) share randomized stimulus
// and are checked against an integer-valued reference model.
`timescale 1ns/100ps
module tb_bcd_countdown_timer;

   localparam int unsigned ND = 4;
   localparam int unsigned W  = 4 * ND;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] count;
      logic         running;
      logic         done;
      logic         expired;
      logic         load_err;
   } obs_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         load, start, pause, tick;
   logic [W-1:0] load_val;

   always #5 clk = ~clk;

   bcd_countdown_timer_if #(.NUM_DIGITS(ND)) bus_a ();
   bcd_countdown_timer_if #(.NUM_DIGITS(ND)) bus_b ();

   assign bus_a.load = load;  assign bus_a.load_val = load_val;
   assign bus_a.start = start; assign bus_a.pause = pause; assign bus_a.tick_in = tick;
   assign bus_b.load = load;  assign bus_b.load_val = load_val;
   assign bus_b.start = start; assign bus_b.pause = pause; assign bus_b.tick_in = tick;

   bcd_countdown_timer #(.NUM_DIGITS(ND), .PRESCALE(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   bcd_countdown_timer #(.NUM_DIGITS(ND), .PRESCALE(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   int   checks = 0;
   int   failures = 0;
   obs_t q_a[$];
   obs_t q_b[$];

   // Reference model: value held as a plain integer
   int m_val[2], m_pre[2], m_st[2], m_shadow[2];
   bit m_done[2], m_err[2];
   int ps[2] = '{1, 4};

   function automatic int bcd_to_int(input logic [W-1:0] b, output bit bad);
      int v = 0;
      int d;
      bad = 1'b0;
      for (int i = int'(ND) - 1; i >= 0; i--) begin
         d = int'(b[4*i +: 4]);
         if (d > 9) begin d = 9; bad = 1'b1; end
         v = v * 10 + d;
      end
      return v;
   endfunction

   function automatic logic [W-1:0] int_to_bcd(input int v);
      logic [W-1:0] r = '0;
      for (int unsigned i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic obs_t model_obs(input int k);
      obs_t o;
      o.count    = int_to_bcd(m_val[k]);
      o.running  = (m_st[k] == S_RUN);
      o.done     = m_done[k];
      o.expired  = (m_st[k] == S_DONE);
      o.load_err = m_err[k];
      return o;
   endfunction

   task automatic model_reset();
      for (int unsigned k = 0; k < 2; k++) begin
         m_val[k] = 0; m_pre[k] = 0; m_st[k] = S_IDLE; m_shadow[k] = 0;
         m_done[k] = 1'b0; m_err[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k);
      bit bad;
      m_done[k] = 1'b0;
      if (load) begin
         m_val[k]    = bcd_to_int(load_val, bad);
         m_err[k]    = bad;
         m_st[k]     = S_IDLE;
         m_pre[k]    = 0;
         m_shadow[k] = m_val[k];
      end else if (m_st[k] == S_IDLE) begin
         if (start && m_val[k] != 0) m_st[k] = S_RUN;
      end else if (m_st[k] == S_PAUSED) begin
         if (start) m_st[k] = S_RUN;
      end else if (m_st[k] == S_RUN) begin
         if (pause && !start) begin
            m_st[k] = S_PAUSED;
         end else if (tick) begin
            m_pre[k]++;
            if (m_pre[k] == ps[k]) begin
               m_pre[k] = 0;
               m_val[k]--;
               if (m_val[k] == 0) begin
                  m_done[k] = 1'b1;
                  if (AUTO && m_shadow[k] != 0) m_val[k] = m_shadow[k];
                  else                          m_st[k]  = S_DONE;
               end
            end
         end
      end
   endtask

   task automatic compare(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t: got count=%h run=%b done=%b exp=%b err=%b, want count=%h run=%b done=%b exp=%b err=%b",
                  name, $time, act.count, act.running, act.done, act.expired, act.load_err,
                  exp.count, exp.running, exp.done, exp.expired, exp.load_err);
      end
   endtask

   function automatic obs_t act_a();
      return {bus_a.count, bus_a.running, bus_a.done, bus_a.expired, bus_a.load_err};
   endfunction
   function automatic obs_t act_b();
      return {bus_b.count, bus_b.running, bus_b.done, bus_b.expired, bus_b.load_err};
   endfunction

   task automatic step(input bit l, input logic [W-1:0] lv, input bit s, input bit p, input bit t);
      @(negedge clk);
      load = l; load_val = lv; start = s; pause = p; tick = t;
      model_step(0);
      model_step(1);
      q_a.push_back(model_obs(0));
      q_b.push_back(model_obs(1));
   endtask

   // Reset pulse lands strictly between edges; outputs must drop at once.
   task automatic async_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      compare("async_rst_a", act_a(), model_obs(0));
      compare("async_rst_b", act_b(), model_obs(1));
      #1 rst = 1'b1;
   endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_a.size() > 0) begin e = q_a.pop_front(); compare("cycle_a", act_a(), e); end
         if (q_b.size() > 0) begin e = q_b.pop_front(); compare("cycle_b", act_b(), e); end
      end
   end

   initial begin : stimulus
      logic [W-1:0] rv;
      rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
      model_reset();
      #1;
      compare("reset_a", act_a(), model_obs(0));
      compare("reset_b", act_b(), model_obs(1));
      #11 rst = 1'b1;

      // Long run with multi-digit borrows
      step(1, 16'h0103, 0, 0, 0);
      step(0, '0, 1, 0, 1);
      repeat (110) step(0, '0, 0, 0, 1);
      // Invalid digit clamps and sets sticky error; a clean load clears it
      step(1, 16'h00A5, 0, 0, 0);
      step(0, '0, 0, 0, 1);
      step(1, 16'h0012, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      // Pause freezes the count, start resumes
      step(1, 16'h0005, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      repeat (2) step(0, '0, 0, 0, 1);
      step(0, '0, 0, 1, 1);
      repeat (10) step(0, '0, 0, 0, 1);
      step(0, '0, 0, 1, 1);
      step(0, '0, 1, 0, 0);
      repeat (24) step(0, '0, 0, 0, 1);
      // Prescaled run from 2
      step(1, 16'h0002, 0, 0, 0);
      step(0, '0, 1, 1, 0);
      repeat (10) step(0, '0, 0, 0, 1);
      // Start from zero ignored; start in DONE ignored; load leaves DONE
      step(1, 16'h0000, 0, 0, 0);
      step(0, '0, 1, 0, 1);
      step(0, '0, 0, 0, 1);
      step(1, 16'h0001, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      repeat (5) step(0, '0, 0, 0, 1);
      step(0, '0, 1, 0, 1);
      step(1, 16'h0009, 0, 0, 1);
      step(0, '0, 0, 0, 0);
      // Load and tick together, start+pause in RUN, then async reset mid-run
      step(0, '0, 1, 0, 0);
      step(1, 16'h0040, 0, 0, 1);
      step(0, '0, 1, 1, 1);
      repeat (6) step(0, '0, 1, 1, 1);
      async_reset();
      step(1, 16'h0002, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      repeat (14) step(0, '0, 0, 0, 1);

      for (int unsigned n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) async_reset();
         if ($urandom_range(0, 29) == 0) begin
            rv = '0;
            rv[3:0] = 4'($urandom_range(0, 15));
            for (int unsigned d = 1; d < ND; d++)
               if ($urandom_range(0, 3) == 0) rv[4*d +: 4] = 4'($urandom_range(0, 15));
            step(1, rv, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
         end else begin
            step(0, 16'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 3) != 0);
         end
      end

      step(0, '0, 0, 0, 0);
      @(posedge clk);
      #3;
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         failures++;
         $display("FAIL drain: got pending=%0d/%0d, want 0/0", q_a.size(), q_b.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Multi-digit BCD countdown timer built from a parametrised chain of down-counting decimal digits.
- User loads a preset, starts, pauses and resumes it; the block decrements once per qualified tick down to 00..0 and then flags completion.
- Sits between the keypad/toggle input logic and the LCD digit driver.
- `count` feeds the display directly, one nibble per digit.

Parameters:
- `NUM_DIGITS`, 4, number of BCD digits (1..8); digit 0 is least significant.
- `PRESCALE`, 1, `clk` cycles per internal tick when `tick_in` is held high (1..65535); 1 means every qualified `tick_in` counts.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `load`  input  1  load `load_val` into the counter (level, sampled each cycle).
- `load_val`  input  4*NUM_DIGITS  preset, packed BCD, digit i at bits [4i+3:4i].
- `start`  input  1  begin or resume counting.
- `pause`  input  1  suspend counting.
- `tick_in`  input  1  count enable from the time base.
- `count`  output  4*NUM_DIGITS  current value, packed BCD.
- `running`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse when the count reaches zero.
- `expired`  output  1  level, high in state DONE.
- `load_err`  output  1  sticky; set when a loaded digit was > 9.

Behaviour:
- **Reset** (`rst`=0, asynchronous): `count`=0, `running`=0, `done`=0, `expired`=0, `load_err`=0, prescaler=0, state=IDLE.
- **States:** IDLE, RUN, PAUSED, DONE.
- **Priority per cycle:** `load` > `start` > `pause` > tick.
- **`load` (any state):**
  - Next cycle `count`=`load_val`, with any digit > 9 replaced by 9.
  - If any digit was replaced, `load_err` is set.
  - State goes to IDLE, prescaler clears.
  - `load_err` clears only on reset or on a load whose digits are all valid.
- **IDLE:**
  - `start`=1 with `count`≠0 -> RUN next cycle.
  - `start` with `count`=0 is ignored and the block stays IDLE.
- **RUN:**
  - `pause`=1 -> PAUSED next cycle; the prescaler value is held.
  - Otherwise, each cycle with `tick_in`=1 advances the prescaler.
  - When the prescaler reaches `PRESCALE`-1 it wraps to 0 and `count` decrements by 1 in BCD in that same edge.
- **Decrement rules:**
  - Digit 0 always receives the decrement.
  - Digit i borrows (0 -> 9) and propagates the borrow to digit i+1 only when all lower digits were 0.
  - Borrow out of the top digit cannot occur, because RUN never decrements from zero.
- **Zero detect:**
  - A decrement from 00..01 gives `count`=0, `done`=1 for exactly that following cycle, `expired`=1, and state -> DONE.
  - Latency: one cycle from the qualifying edge to the `count` update and `done`.
- **PAUSED:**
  - `count` is frozen and `tick_in` is ignored.
  - `start` -> RUN, resuming with the held prescaler.
  - `pause` while already PAUSED has no effect.
- **DONE:**
  - `count` stays 0 and `expired` stays 1.
  - `start` is ignored.
  - Only `load` (or reset) leaves DONE; `expired` clears on load.
- **Asynchronous reset mid-RUN** aborts immediately to the reset values.
- **Simultaneous events:**
  - `start`+`pause` in IDLE -> RUN.
  - `start`+`pause` in RUN -> stays RUN.
  - `load`+`tick_in` -> load wins and no decrement occurs.

Optional Feature:
`BCD_TIMER_AUTO_RELOAD_EN`
- **Defined:**
  - A shadow register captures the clamped `load_val` on every `load`.
  - On expiry the block still pulses `done`, but `count` takes the shadow value instead of 0 and the state stays RUN.
  - `expired` stays 0.
  - A shadow value of all-zero behaves as not defined.
- **Not defined:** no shadow register; behaviour exactly as above.

Decomposition:
- **Shared package** `bcd_timer_pkg`:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3);
  - `BCD_MAX`=4'd9, `BCD_ZERO`=4'd0;
  - a function returning a clamped BCD nibble.
- **Sub-module** `bcd_down_cell`:
  - One instance per digit.
  - Combinational inputs: `dec_in`, `load_en`, `load_nib`; registered output `nib`; outputs `borrow_out` and `is_zero`.
  - The top level is generated over `NUM_DIGITS` and contains the FSM and prescaler.

Test Plan:
1. `NUM_DIGITS`=4, `PRESCALE`=1: load 0x0103, start, `tick_in`=1 continuously -> `count` 0102, 0101, 0100, 0099 (borrow across two digits) … reaches 0000 after 103 ticks; `done` high exactly one cycle; `expired`=1.
2. Load 0x00A5 -> `count`=0095, `load_err`=1; then load 0x0012 -> `load_err`=0.
3. Load 0x0005, start, 2 ticks, pause, 10 ticks -> `count` stays 0003; start, 3 ticks -> 0000 with `done` pulse.
4. `PRESCALE`=4, load 0x0002, start, `tick_in` high 8 cycles -> `count` 0001 after the 4th tick, 0000 plus `done` after the 8th.
5. Load 0x0000, start -> stays IDLE, `running`=0, no `done`; in DONE, start is ignored, load 0x0009 clears `expired`.
6. Assert `rst`=0 mid-RUN between clock edges -> outputs go to reset values immediately; with `BCD_TIMER_AUTO_RELOAD_EN`, load 0x0002, run 2 ticks -> `done` pulse, `count`=0002, `running`=1.
